// File: rtl/fp_log_pkg.sv
// Shared constants, flag type and table generator for the small-float log unit.
// The mantissa table is computed at elaboration so it tracks MANT_W/FRAC_W.
package fp_log_pkg;

  localparam int DEF_EXP_W  = 5;
  localparam int DEF_MANT_W = 6;
  localparam int DEF_FRAC_W = 14;
  localparam int DEF_OUT_W  = 20;

  // ln(2) in Q0.16, kept one bit wider so it can be used as a positive signed operand
  localparam logic [16:0] LN2_Q16 = 17'd45426;

  typedef struct packed {
    logic zero;
    logic neg;
    logic special;
  } log_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int unsigned rom_entry(input int idx, input int mant_w, input int frac_w);
    real l2;
    l2 = $ln(1.0 + real'(idx) / real'(1 << mant_w)) / $ln(2.0);
    return unsigned'($rtoi(l2 * real'(1 << frac_w) + 0.5));
  endfunction

endpackage

// File: rtl/fp_log_mant_rom.sv
// log2(1 + idx/2^MANT_W) table in unsigned Q0.FRAC_W, combinational read.
module fp_log_mant_rom
  import fp_log_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic [MANT_W-1:0] idx_i,
  output logic [FRAC_W-1:0] frac_o
);

  localparam int DEPTH = 1 << MANT_W;

  logic [FRAC_W-1:0] rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam int unsigned ENTRY = rom_entry(gi, MANT_W, FRAC_W);
    assign rom[gi] = ENTRY[FRAC_W-1:0];
  end

  assign frac_o = rom[idx_i];

endmodule

// File: rtl/fp_log_pipe.sv
// Three-stage elastic log2/ln unit for small custom floats: decode, table lookup,
// then ln scaling and clamping of zero/inf/NaN.
module fp_log_pipe
  import fp_log_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   in_data,
  input  logic                    in_ln,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_log,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic                    out_special
);

  localparam int BIAS = fp_bias(EXP_W);
  localparam int IW   = OUT_W - FRAC_W;
  localparam int PW   = OUT_W + 17;

  if ((BIAS - 1 + MANT_W) > (1 << (IW - 1)) || BIAS > ((1 << (IW - 1)) - 1)) begin : g_bad_out_w
    $error("fp_log_pipe: OUT_W-FRAC_W too small for the exponent range");
  end

  // Stage 1: decoded exponent, table index, flags
  logic              v1_q;
  logic [IW-1:0]     int1_q, int1_d;
  logic [MANT_W-1:0] idx1_q, idx1_d;
  log_flags_t        flags1_q, flags1_d;
  logic              ln1_q;
  // Stage 2: fixed-point log2
  logic              v2_q;
  logic [OUT_W-1:0]  val2_q, val2_d;
  log_flags_t        flags2_q;
  logic              ln2_q;
  // Stage 3: final result
  logic              v3_q;
  logic [OUT_W-1:0]  log3_q, log3_d;
  log_flags_t        flags3_q;

  logic ready1, ready2, ready3;
  logic [EXP_W-1:0]  exp_in;
  logic [MANT_W-1:0] mant_in;
  int                lead_pos;
  logic [FRAC_W-1:0] rom_frac;
  logic signed [PW-1:0] ln_prod, ln_sum;
  logic ln_unused;

  assign ready3   = !v3_q || out_ready;
  assign ready2   = !v2_q || ready3;
  assign ready1   = !v1_q || ready2;
  assign in_ready = ready1;

  assign exp_in  = in_data[EXP_W+MANT_W-1:MANT_W];
  assign mant_in = in_data[MANT_W-1:0];

  always_comb begin
    lead_pos = 0;
    for (int i = 0; i < MANT_W; i++) begin
      if (mant_in[i]) lead_pos = i;
    end
  end

  always_comb begin
    int1_d   = IW'(exp_in) - IW'(BIAS);
    idx1_d   = mant_in;
    flags1_d = '{zero: 1'b0, neg: in_data[EXP_W+MANT_W], special: 1'b0};
    if (exp_in == '1) begin
      flags1_d.special = 1'b1;
    end else if (exp_in == '0) begin
      if (mant_in == '0) begin
        flags1_d.zero = 1'b1;
      end else begin
        // Subnormal: normalise so the leading one becomes the implicit bit
        int1_d = IW'(1 - BIAS - MANT_W) + IW'(lead_pos);
        idx1_d = MANT_W'(mant_in << (MANT_W - lead_pos));
      end
    end
  end

  fp_log_mant_rom #(
    .MANT_W(MANT_W),
    .FRAC_W(FRAC_W)
  ) u_rom (
    .idx_i (idx1_q),
    .frac_o(rom_frac)
  );

  // frac < 2^FRAC_W, so (int << FRAC_W) + frac is a plain concatenation
  assign val2_d = {int1_q, rom_frac};

  always_comb begin
    ln_prod = PW'($signed(val2_q)) * PW'($signed(LN2_Q16));
    ln_sum  = ln_prod + PW'(32768);
    log3_d  = val2_q;
    if (ln2_q)             log3_d = ln_sum[OUT_W+15:16];
    if (flags2_q.zero)     log3_d = {1'b1, {(OUT_W-1){1'b0}}};
    if (flags2_q.special)  log3_d = {1'b0, {(OUT_W-1){1'b1}}};
  end

  assign ln_unused = ^{ln_sum[PW-1:OUT_W+16], ln_sum[15:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      int1_q   <= '0;
      idx1_q   <= '0;
      flags1_q <= '0;
      ln1_q    <= 1'b0;
      v2_q     <= 1'b0;
      val2_q   <= '0;
      flags2_q <= '0;
      ln2_q    <= 1'b0;
      v3_q     <= 1'b0;
      log3_q   <= '0;
      flags3_q <= '0;
    end else begin
      if (ready1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          int1_q   <= int1_d;
          idx1_q   <= idx1_d;
          flags1_q <= flags1_d;
          ln1_q    <= in_ln;
        end
      end
      if (ready2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          val2_q   <= val2_d;
          flags2_q <= flags1_q;
          ln2_q    <= ln1_q;
        end
      end
      if (ready3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          log3_q   <= log3_d;
          flags3_q <= flags2_q;
        end
      end
    end
  end

  assign out_valid   = v3_q;
  assign out_log     = log3_q;
  assign out_zero    = flags3_q.zero;
  assign out_neg     = flags3_q.neg;
  assign out_special = flags3_q.special;

endmodule

// File: tb/tb_fp_log_pipe.sv
// Scoreboard bench for fp_log_pipe: driver pushes expected results, monitor pops on output handshakes.
module tb_fp_log_pipe;

  localparam int DW    = 12;
  localparam int OUT_W = 20;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic             ln;
    logic [OUT_W-1:0] log;
    logic             zero;
    logic             neg;
    logic             special;
    logic             lat_chk;
    int               acc_cyc;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_ln;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_log;
  logic             out_zero;
  logic             out_neg;
  logic             out_special;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  int   cyc    = 0;
  bit   hold_pending = 1'b0;
  logic [OUT_W+3:0] held;

  fp_log_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ln      (in_ln),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_log    (out_log),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_special(out_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: log of the real magnitude, quantised to Q.14, optionally rescaled to ln
  function automatic exp_t model(input logic [DW-1:0] d, input logic ln);
    exp_t   e;
    int     ex;
    int     m;
    real    mag;
    real    l2;
    longint v;
    e = '0;
    e.data = d;
    e.ln   = ln;
    e.neg  = d[11];
    ex = int'(d[10:6]);
    m  = int'(d[5:0]);
    if (ex == 31) begin
      e.special = 1'b1;
      e.log     = 20'h7FFFF;
    end else if (ex == 0 && m == 0) begin
      e.zero = 1'b1;
      e.log  = 20'h80000;
    end else begin
      if (ex == 0) mag = real'(m) * (2.0 ** (-20));
      else         mag = (1.0 + real'(m) / 64.0) * (2.0 ** (ex - 15));
      l2 = $ln(mag) / $ln(2.0);
      v  = longint'($floor(l2 * 16384.0 + 0.5));
      if (ln) v = longint'($floor(real'(v) * 45426.0 / 65536.0 + 0.5));
      e.log = v[OUT_W-1:0];
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [DW-1:0] d, input logic l, input logic [OUT_W-1:0] lg,
                              input logic z, input logic n, input logic s);
    exp_t e;
    e = '0;
    e.data = d; e.ln = l; e.log = lg; e.zero = z; e.neg = n; e.special = s; e.lat_chk = 1'b1;
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = DW'($urandom_range(0, 4095));
    case ($urandom_range(0, 7))
      0: w[10:6] = 5'd0;
      1: w[10:6] = 5'd31;
      default: ;
    endcase
    return w;
  endfunction

  task automatic send(input exp_t e, input int rdy_pct);
    bit done;
    exp_t t;
    done = 1'b0;
    t = e;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = t.data;
      in_ln     = t.ln;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (in_ready) begin
        t.acc_cyc = cyc;
        exp_q.push_back(t);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept in=%03h got no in_ready within 60 cycles, required acceptance", t.data);
    end
  endtask

  task automatic idle(input int n, input int rdy_pct);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding results, required 0", exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks stall stability
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checks++;
        if ({out_valid, out_log, out_zero, out_neg, out_special} !== held) begin
          errors++;
          $display("FAIL stall_hold got %h, required %h", {out_valid, out_log, out_zero, out_neg, out_special}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got log=%05h with empty scoreboard, required none", out_log);
        end else begin
          e = exp_q.pop_front();
          txn++;
          if (out_log !== e.log || out_zero !== e.zero || out_neg !== e.neg || out_special !== e.special) begin
            errors++;
            $display("FAIL result in=%03h ln=%0d got log=%05h z=%0d n=%0d s=%0d, required log=%05h z=%0d n=%0d s=%0d",
                     e.data, e.ln, out_log, out_zero, out_neg, out_special, e.log, e.zero, e.neg, e.special);
          end else begin
            $display("txn %0d in=%03h ln=%0d out=%05h z=%0d n=%0d s=%0d", txn, e.data, e.ln, out_log,
                     out_zero, out_neg, out_special);
          end
          if (e.lat_chk) begin
            checks++;
            if (cyc - e.acc_cyc != 3) begin
              errors++;
              $display("FAIL latency in=%03h got %0d cycles, required 3", e.data, cyc - e.acc_cyc);
            end
          end
        end
      end
      hold_pending = out_valid && !out_ready;
      held = {out_valid, out_log, out_zero, out_neg, out_special};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dir[$];
    int   acc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ln = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_log !== '0 || out_zero !== 1'b0 || out_neg !== 1'b0 ||
        out_special !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b log=%05h z=%b n=%b s=%b rdy=%b, required v=0 log=00000 flags=0 rdy=1",
               out_valid, out_log, out_zero, out_neg, out_special, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases with hand-derived results, full throughput
    dir.push_back(mk(12'h3C0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0));
    dir.push_back(mk(12'h400, 1'b0, 20'h04000, 1'b0, 1'b0, 1'b0));
    dir.push_back(mk(12'h3E0, 1'b0, 20'h02570, 1'b0, 1'b0, 1'b0));
    dir.push_back(mk(12'h001, 1'b0, 20'hB0000, 1'b0, 1'b0, 1'b0));
    dir.push_back(mk(12'h020, 1'b0, 20'hC4000, 1'b0, 1'b0, 1'b0));
    dir.push_back(mk(12'h400, 1'b1, 20'h02C5D, 1'b0, 1'b0, 1'b0));
    dir.push_back(mk(12'hBC0, 1'b0, 20'h00000, 1'b0, 1'b1, 1'b0));
    dir.push_back(mk(12'h000, 1'b0, 20'h80000, 1'b1, 1'b0, 1'b0));
    dir.push_back(mk(12'h7C0, 1'b0, 20'h7FFFF, 1'b0, 1'b0, 1'b1));
    dir.push_back(mk(12'h7C1, 1'b1, 20'h7FFFF, 1'b0, 1'b0, 1'b1));
    dir.push_back(mk(12'h800, 1'b1, 20'h80000, 1'b1, 1'b1, 1'b0));
    foreach (dir[i]) send(dir[i], 100);
    drain();

    // Stall: out_ready low for 5 cycles while inputs keep coming
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = rand_word();
      in_ln     = 1'($urandom_range(0, 1));
      out_ready = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(in_data, in_ln));
        acc++;
      end
    end
    checks++;
    if (acc != 3) begin
      errors++;
      $display("FAIL stall_accepts got %0d, required 3", acc);
    end
    drain();

    // Randomised traffic with back-pressure, interrupted by a one-cycle reset
    for (int n = 0; n < 300; n++) begin
      exp_t e;
      e = model(rand_word(), 1'($urandom_range(0, 1)));
      send(e, 70);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 70);
      if (n == 150) begin
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL mid_reset got v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready);
        end
        idle(5, 100);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_log_pipe.md
Name: fp_log_pipe

Overview:
Pipelined, parametrised logarithm unit for the small custom float formats (default FP12: 1 sign, 5 exp, 6 mant). Produces a single signed fixed-point result, either log2(|x|) or ln(|x|) selected per transaction, plus class flags. It has valid/ready handshakes and sits in front of the log-domain multiply/accumulate path. Subnormals are normalised by a leading-zero count and reuse the normal mantissa table, so no separate subnormal table is needed.

Parameters:
EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1
MANT_W, 6, mantissa field width; table has 2^MANT_W entries
FRAC_W, 14, fractional bits of the result
OUT_W, 20, total result width, signed two's complement; elaboration error if the integer part cannot hold -(bias-1+MANT_W) or +bias

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  unit can accept an input this cycle
in_data  in  1+EXP_W+MANT_W  {sign, exp, mant}
in_ln  in  1  1 = natural log, 0 = log2
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_log  out  OUT_W  signed Q(OUT_W-FRAC_W).FRAC_W result
out_zero  out  1  input was ±0
out_neg  out  1  input sign bit; the result is the log of the magnitude
out_special  out  1  exponent was all ones (inf or NaN)

Behaviour:
- Reset: all stage valids 0, out_valid 0, out_log 0, all flags 0. A reset mid-operation drops all in-flight data.
- Latency: 3 cycles from an accepted input to out_valid when there is no stall. Throughput is 1 per cycle.
- Handshake: a transfer happens when valid && ready. The pipeline is elastic.
  - Stage k loads when stage k is empty or stage k advances.
  - Stage 3 advances when out_ready is 1.
  - in_ready = !v1 || v2 free-or-advancing (combinational chain).
  - While out_valid=1 and out_ready=0, out_* hold stable. in_ready falls only once all 3 stages are full.
- S1 (decode):
  - Normal (exp != 0, != all ones): int = exp-bias, idx = mant.
  - Subnormal (exp=0, mant!=0): p = index of the leading 1 of mant; int = 1-bias-MANT_W+p; idx = (mant << (MANT_W-p)) truncated to MANT_W bits.
  - Zero (exp=0, mant=0): set zero.
  - exp all ones: set special.
  - Register int, idx, flags, ln.
- S2 (lookup): frac = ROM[idx] = round(log2(1+idx/2^MANT_W) * 2^FRAC_W), unsigned FRAC_W bits. ROM[0]=0. Register v2 = (int<<FRAC_W) + frac, sign-extended to OUT_W.
- S3 (scale/clamp):
  - If ln=1: out = round-half-up((v2 * LN2_Q16) >>> 16), where LN2_Q16 = 45426. Use a signed multiply; rounding is arithmetic, toward +inf on ties.
  - If zero: out = most-negative (1 followed by zeros).
  - If special: out = most-positive.
  - Zero and special override ln scaling.
- Flags pass through unchanged. out_neg reports the sign for every class, including zero and special.

Decomposition:
- Package fp_log_pkg holds:
  - format constants: EXP_W/MANT_W defaults, bias function
  - LN2_Q16
  - elaboration-time constant function computing the ROM contents using $ln
  - flag struct {zero, neg, special}
- One sub-module, fp_log_mant_rom: parametrised by MANT_W and FRAC_W, combinational read, contents from the package function.
- The leading-zero count stays inline in S1.

Test Plan:
- 0x3C0 (1.0), in_ln=0 -> out_log=0x00000 after 3 cycles; all flags 0.
- Back-to-back 0x400 (2.0), 0x3E0 (1.5), log2 -> 0x04000 then 0x02570 (9584) on consecutive cycles.
- 0x001 (min subnormal 2^-20) -> 0xB0000 (-20.0). Also 0x020 (2^-15) -> -15.0 = 0xC4000.
- 0x400 with in_ln=1 -> 0x02C5D (11357). Also 0xBC0 (-1.0) -> out 0, out_neg=1.
- 0x000 -> 0x80000 with zero=1. 0x7C0 and 0x7C1 -> 0x7FFFF with special=1. 0x800 (-0) -> zero=1, neg=1.
- Stall and reset:
  - Hold out_ready=0 for 5 cycles during a stream: in_ready drops after 3 accepts, out_* stay stable, no loss or duplication on release.
  - Assert rst_n=0 for one cycle mid-stream: out_valid=0 on the next cycle and no stale outputs appear afterwards.
